// File: rtl/dm_stack_mem.sv
//==============================================================================
// Module  : dm_stack_mem
// Brief   : Data memory with registered load/store port and a hardware stack
//           growing downward from STACK_BASE to STACK_LIMIT. Optional
//           overflow/underflow guarding is enabled with DM_STACK_GUARD_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dm_stack_mem #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 9,
   parameter int STACK_BASE  = 2**ADDR_W - 1,
   parameter int STACK_LIMIT = 2**ADDR_W - 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rez,
   input  logic              load,
   input  logic              store,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] sp,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              err
);

   localparam int                c_depth   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] c_full_sp = ADDR_W'(STACK_LIMIT - 1);

   logic [DATA_W-1:0] r_mem [c_depth];
   logic [ADDR_W-1:0] r_sp;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_err;

   logic              w_conflict;
   logic              w_push_block;
   logic              w_pop_block;
   logic              w_do_load;
   logic              w_do_store;
   logic              w_do_push;
   logic              w_do_pop;
   logic              w_reject;
   logic [ADDR_W-1:0] w_sp_inc;

   // Any pair of commands high at once is a conflict.
   assign w_conflict = (load & store) | (load & push) | (load & pop) |
                       (store & push) | (store & pop) | (push & pop);

`ifdef DM_STACK_GUARD_EN
   assign w_push_block = push & stack_full;
   assign w_pop_block  = pop  & stack_empty;
`else
   assign w_push_block = 1'b0;
   assign w_pop_block  = 1'b0;
`endif

   assign w_do_load  = load  & ~w_conflict;
   assign w_do_store = store & ~w_conflict;
   assign w_do_push  = push  & ~w_conflict & ~w_push_block;
   assign w_do_pop   = pop   & ~w_conflict & ~w_pop_block;
   assign w_reject   = w_conflict | w_push_block | w_pop_block;
   assign w_sp_inc   = r_sp + 1'b1;

   // Memory contents survive reset; only the write is suppressed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_do_store)
            r_mem[address] <= rez;
         else if (w_do_push)
            r_mem[r_sp] <= rez;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp    <= c_base;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_do_load | w_do_pop;
         r_err   <= w_reject;
         if (w_do_push)
            r_sp <= r_sp - 1'b1;
         else if (w_do_pop)
            r_sp <= w_sp_inc;
         if (w_do_load)
            r_data <= r_mem[address];
         else if (w_do_pop)
            r_data <= r_mem[w_sp_inc];
      end
   end

   assign data_out    = r_data;
   assign data_valid  = r_valid;
   assign err         = r_err;
   assign sp          = r_sp;
   assign stack_empty = (r_sp == c_base);
   assign stack_full  = (r_sp == c_full_sp);

endmodule

`default_nettype wire

// File: tb/tb_dm_stack_mem.sv
//==============================================================================
// Module  : tb_dm_stack_mem
// Brief   : Directed bench for dm_stack_mem with a word-level reference model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dm_stack_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] rez = '0;
   logic        load = 1'b0, store = 1'b0, push = 1'b0, pop = 1'b0;
   logic [8:0]  address = '0;
   logic [15:0] data_out;
   logic        data_valid;
   logic [8:0]  sp;
   logic        stack_empty, stack_full, err;

   dm_stack_mem dut (
      .clk(clk), .rst(rst), .rez(rez), .load(load), .store(store),
      .push(push), .pop(pop), .address(address), .data_out(data_out),
      .data_valid(data_valid), .sp(sp), .stack_empty(stack_empty),
      .stack_full(stack_full), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [15:0] m_mem [512];
   bit          m_known [512];
   int          m_sp;
   logic [15:0] m_dout;
   bit          m_dout_known;
   bit          m_dv, m_err;
   bit          m_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit l, input bit s, input bit pu,
                        input bit po, input int a, input logic [15:0] d);
      int n;
      n = int'(l) + int'(s) + int'(pu) + int'(po);
      if (r) begin
         m_sp = 511; m_dout = '0; m_dout_known = 1'b1; m_dv = 1'b0; m_err = 1'b0;
      end else begin
         m_dv = 1'b0; m_err = 1'b0;
         if (n > 1) begin
            m_err = 1'b1;
         end else if (s) begin
            m_mem[a] = d; m_known[a] = 1'b1;
         end else if (l) begin
            m_dout = m_mem[a]; m_dout_known = m_known[a]; m_dv = 1'b1;
         end else if (pu) begin
`ifdef DM_STACK_GUARD_EN
            if (m_sp == 383) m_err = 1'b1;
            else begin
               m_mem[m_sp] = d; m_known[m_sp] = 1'b1; m_sp = (m_sp + 511) % 512;
            end
`else
            m_mem[m_sp] = d; m_known[m_sp] = 1'b1; m_sp = (m_sp + 511) % 512;
`endif
         end else if (po) begin
`ifdef DM_STACK_GUARD_EN
            if (m_sp == 511) m_err = 1'b1;
            else begin
               m_sp = (m_sp + 1) % 512;
               m_dout = m_mem[m_sp]; m_dout_known = m_known[m_sp]; m_dv = 1'b1;
            end
`else
            m_sp = (m_sp + 1) % 512;
            m_dout = m_mem[m_sp]; m_dout_known = m_known[m_sp]; m_dv = 1'b1;
`endif
         end
      end
      m_ready = 1'b1;
   endtask

   // One clock of stimulus; the model advances just after the sampling edge.
   task automatic step(input bit r, input bit l, input bit s, input bit pu,
                       input bit po, input logic [8:0] a, input logic [15:0] d);
      rst = r; load = l; store = s; push = pu; pop = po; address = a; rez = d;
      @(posedge clk);
      #1;
      model(r, l, s, pu, po, int'(a), d);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 9'h000, 16'h0000);
   endtask

   always @(negedge clk) begin
      if (m_ready) begin
         check("sp", 32'(sp), 32'(m_sp));
         check("stack_empty", 32'(stack_empty), 32'(m_sp == 511));
         check("stack_full", 32'(stack_full), 32'(m_sp == 383));
         check("data_valid", 32'(data_valid), 32'(m_dv));
         check("err", 32'(err), 32'(m_err));
         if (m_dout_known) check("data_out", 32'(data_out), 32'(m_dout));
      end
   end

   initial begin
      for (int i = 0; i < 512; i++) m_known[i] = 1'b0;

      step(1, 0, 0, 0, 0, 9'h000, 16'h0000);
      check("reset_sp", 32'(sp), 32'd511);
      check("reset_dout", 32'(data_out), 32'h0);
      check("reset_valid", 32'(data_valid), 32'd0);
      idle();

      // Store then load
      step(0, 0, 1, 0, 0, 9'h001, 16'h1234);
      check("store_valid", 32'(data_valid), 32'd0);
      step(0, 1, 0, 0, 0, 9'h001, 16'h0000);
      check("load_data", 32'(data_out), 32'h1234);
      check("load_valid", 32'(data_valid), 32'd1);
      check("load_sp", 32'(sp), 32'd511);
      check("load_empty", 32'(stack_empty), 32'd1);
      idle();
      check("idle_valid", 32'(data_valid), 32'd0);
      check("idle_hold", 32'(data_out), 32'h1234);

      step(0, 0, 1, 0, 0, 9'h000, 16'h0F0F);
      step(0, 0, 1, 0, 0, 9'd383, 16'hBEEF);

      // Push/pop ordering
      step(0, 0, 0, 1, 0, 9'h000, 16'h5678);
      check("push1_sp", 32'(sp), 32'd510);
      step(0, 0, 0, 1, 0, 9'h000, 16'hABCD);
      check("push2_sp", 32'(sp), 32'd509);
      step(0, 0, 0, 0, 1, 9'h000, 16'h0000);
      check("pop1_data", 32'(data_out), 32'hABCD);
      check("pop1_sp", 32'(sp), 32'd510);
      step(0, 0, 0, 0, 1, 9'h000, 16'h0000);
      check("pop2_data", 32'(data_out), 32'h5678);
      check("pop2_sp", 32'(sp), 32'd511);
      check("pop2_empty", 32'(stack_empty), 32'd1);

      // Push immediately followed by pop
      step(0, 0, 0, 1, 0, 9'h000, 16'h4242);
      step(0, 0, 0, 0, 1, 9'h000, 16'h0000);
      check("pushpop_data", 32'(data_out), 32'h4242);
      check("pushpop_sp", 32'(sp), 32'd511);

      // Conflict: store + load
      step(0, 0, 1, 0, 0, 9'h010, 16'h1111);
      step(0, 1, 1, 0, 0, 9'h010, 16'h2222);
      check("conflict_err", 32'(err), 32'd1);
      check("conflict_valid", 32'(data_valid), 32'd0);
      idle();
      check("conflict_err_clear", 32'(err), 32'd0);
      step(0, 1, 0, 0, 0, 9'h010, 16'h0000);
      check("conflict_mem", 32'(data_out), 32'h1111);

      // Conflict: push + pop leaves sp alone
      step(0, 0, 0, 1, 1, 9'h000, 16'h7777);
      check("conflict2_err", 32'(err), 32'd1);
      check("conflict2_sp", 32'(sp), 32'd511);

      // Pop on empty stack
      step(0, 0, 0, 0, 1, 9'h000, 16'h0000);
`ifdef DM_STACK_GUARD_EN
      check("underflow_err", 32'(err), 32'd1);
      check("underflow_sp", 32'(sp), 32'd511);
      check("underflow_valid", 32'(data_valid), 32'd0);
`else
      check("underflow_sp", 32'(sp), 32'd0);
      check("underflow_data", 32'(data_out), 32'h0F0F);
      check("underflow_valid", 32'(data_valid), 32'd1);
      check("underflow_err", 32'(err), 32'd0);
`endif
      step(1, 0, 0, 0, 0, 9'h000, 16'h0000);
      idle();

      // Fill the stack
      for (int i = 0; i < 128; i++)
         step(0, 0, 0, 1, 0, 9'h000, 16'h3000 + 16'(i));
      check("full_sp", 32'(sp), 32'd383);
      check("full_flag", 32'(stack_full), 32'd1);
      step(0, 0, 0, 1, 0, 9'h000, 16'hDEAD);
`ifdef DM_STACK_GUARD_EN
      check("overflow_err", 32'(err), 32'd1);
      check("overflow_sp", 32'(sp), 32'd383);
      step(0, 1, 0, 0, 0, 9'd383, 16'h0000);
      check("overflow_mem", 32'(data_out), 32'hBEEF);
`else
      check("overflow_err", 32'(err), 32'd0);
      check("overflow_sp", 32'(sp), 32'd382);
      step(0, 1, 0, 0, 0, 9'd383, 16'h0000);
      check("overflow_mem", 32'(data_out), 32'hDEAD);
`endif

      // Reset wins over a simultaneous push
      step(1, 0, 0, 1, 0, 9'h000, 16'h00FF);
      check("rstpush_sp", 32'(sp), 32'd511);
      check("rstpush_valid", 32'(data_valid), 32'd0);
      check("rstpush_err", 32'(err), 32'd0);
      step(0, 1, 0, 0, 0, 9'd511, 16'h0000);
      check("rstpush_mem", 32'(data_out), 32'h3000);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dm_stack_mem.md
# dm_stack_mem

Parametrised data memory with a hardware-managed stack for the 16-bit processor. It serves explicit load/store accesses from the execute stage and push/pop operations against an internally maintained stack pointer. Reads are registered with a valid strobe. Occupancy flags and a conflict/error strobe are exported to the control unit.

## Interface
- DATA_W, 16, word width of rez, data_out and memory words
- ADDR_W, 9, address width; memory holds 2**ADDR_W words
- STACK_BASE, 2**ADDR_W-1, reset value of sp and the topmost stack slot; the stack grows downward
- STACK_LIMIT, 2**ADDR_W-128, lowest address the stack may occupy; must satisfy 1 <= STACK_LIMIT <= STACK_BASE

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rez  input  DATA_W  write data for store and push
- load  input  1  read mem[address]
- store  input  1  write rez to mem[address]
- push  input  1  write rez to mem[sp], then decrement sp
- pop  input  1  increment sp, then read mem[sp+1]
- address  input  ADDR_W  address for load/store
- data_out  output  DATA_W  registered read data
- data_valid  output  1  one-cycle strobe: data_out updated by load/pop
- sp  output  ADDR_W  current stack pointer; points to the next free slot
- stack_empty  output  1  sp == STACK_BASE
- stack_full  output  1  sp == STACK_LIMIT-1, i.e. (STACK_BASE-STACK_LIMIT+1) entries
- err  output  1  one-cycle strobe: command rejected

## Operation
- Commands are sampled each rising edge. Exactly one of load/store/push/pop may be high.
- Two or more commands high in the same cycle: nothing executes, sp and memory are unchanged, and err=1 the next cycle.
- store: mem[address] <= rez.
- load: data_out <= mem[address]; data_valid=1.
- push: mem[sp] <= rez; sp <= sp-1.
- pop: sp <= sp+1; data_out <= mem[sp+1]; data_valid=1.
- No command: data_out holds its last value; data_valid=0; err=0.
- Pointer arithmetic is modulo 2**ADDR_W.
- stack_empty and stack_full are combinational from the registered sp.
- load/store are not restricted to the data region. Stores into [STACK_LIMIT, STACK_BASE] are legal and corrupt stack contents by design.
- Reset:
  - sp=STACK_BASE, data_out=0, data_valid=0, err=0.
  - Memory contents are not cleared.
  - A reset asserted in the same cycle as any command wins: the command is discarded.

## Timing
- Read latency is 1 cycle. data_out and data_valid change on the edge that samples load/pop.
- Write takes effect on the sampling edge. A load of the same address in the next cycle returns the new data.
- Push followed immediately by pop returns the pushed word, with sp restored, one cycle after the pop edge.
- Back-to-back commands are accepted every cycle. There are no stall or ready signals.
- err and data_valid are mutually exclusive in any cycle.

## Configuration
- Macro: DM_STACK_GUARD_EN.
- Defined:
  - push while stack_full, or pop while stack_empty, is a no-op: no write, sp unchanged, data_out held.
  - err=1 the next cycle and data_valid=0.
- Undefined:
  - No guarding. Push when full writes mem[STACK_LIMIT-1] and decrements sp below the limit.
  - Pop when empty wraps sp to STACK_BASE+1 modulo 2**ADDR_W and returns that word.
  - err is driven only by command conflicts.

## Test plan
- Reset, then store rez=16'h1234 at address 9'h001; load 9'h001 next cycle -> data_out=16'h1234 with data_valid=1 one cycle later; sp=511, stack_empty=1.
- Push 16'h5678, then push 16'hABCD, then pop twice:
  - sp goes 511 -> 510 -> 509 -> 510 -> 511.
  - Pops return 16'hABCD then 16'h5678.
  - stack_empty=1 at the end.
- Assert store and load together at address 9'h010 -> err=1 for one cycle, data_valid=0, mem[9'h010] unchanged (confirmed by a subsequent load).
- 128 consecutive pushes -> stack_full=1 with sp=383. With DM_STACK_GUARD_EN, a 129th push gives err=1, sp=383, and mem[383] is unchanged. Without the macro, sp=382 and mem[383] is written.
- Pop on an empty stack:
  - With DM_STACK_GUARD_EN: err=1, sp=511.
  - Without: sp=0, data_out=mem[0], data_valid=1.
- Push 16'h00FF with rst asserted in the same cycle -> sp=511, data_valid=0, err=0, and mem[511] is unchanged.
